load_hazard_scoreboard: RTL and testbench

Parametrised successor to the single-stage load-use hazard detector in the MIPS pipeline; sits beside the ID stage and drives PC write, IF/ID write, IF/ID flush and the ID/EX control-zeroing mux. It adds a configurable load-to-use distance via a shift-register scoreboard, per-operand use qualification, a register-0 exemption, and a global freeze on memory wait or debug halt. It also adds a branch flush and saturating stall counters for performance monitoring.

---
 rtl/load_hazard_scoreboard_pkg.sv | 15 +
 rtl/load_scoreboard_entry.sv | 37 +++
 rtl/load_hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_load_hazard_scoreboard.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_hazard_scoreboard_pkg.sv
// Shared constants and state encoding for the load-use hazard scoreboard.
package load_hazard_scoreboard_pkg;

  localparam int DEFAULT_REG_ADDRS_BITS = 5;
  localparam int DEFAULT_LOAD_LATENCY   = 1;
  localparam int DEFAULT_COUNT_BITS     = 16;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    HALT       = 2'd3
  } hazard_state_e;

endpackage

// File: rtl/load_scoreboard_entry.sv
// One scoreboard slot: a {valid, rd} register plus its match against the ID operands.
module load_scoreboard_entry
  import load_hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDRS_BITS = DEFAULT_REG_ADDRS_BITS
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_shift,
  input  logic                      i_next_valid,
  input  logic [REG_ADDRS_BITS-1:0] i_next_rd,
  input  logic [REG_ADDRS_BITS-1:0] i_id_rs,
  input  logic [REG_ADDRS_BITS-1:0] i_id_rt,
  input  logic                      i_id_uses_rs,
  input  logic                      i_id_uses_rt,
  output logic                      o_valid,
  output logic [REG_ADDRS_BITS-1:0] o_rd,
  output logic                      o_match
);

  // i_shift low holds the slot; high takes whatever the previous slot (or ID) offers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_rd    <= '0;
    end else if (i_shift) begin
      o_valid <= i_next_valid;
      o_rd    <= i_next_rd;
    end
  end

  // r0 is hardwired to zero, so a pending load to it never blocks a reader.
  assign o_match = o_valid && (o_rd != '0) &&
                   ((i_id_uses_rs && (o_rd == i_id_rs)) ||
                    (i_id_uses_rt && (o_rd == i_id_rt)));

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit beside ID: multi-cycle load scoreboard, branch flush,
// memory-wait / debug-halt freeze and saturating stall counters.
module load_hazard_scoreboard
  import load_hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDRS_BITS = DEFAULT_REG_ADDRS_BITS,
  parameter int LOAD_LATENCY   = DEFAULT_LOAD_LATENCY,
  parameter int COUNT_BITS     = DEFAULT_COUNT_BITS
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [REG_ADDRS_BITS-1:0] i_id_rs,
  input  logic [REG_ADDRS_BITS-1:0] i_id_rt,
  input  logic                      i_id_uses_rs,
  input  logic                      i_id_uses_rt,
  input  logic                      i_id_MemRead,
  input  logic                      i_branch_taken,
  input  logic                      i_mem_req,
  input  logic                      i_mem_ready,
  input  logic                      i_halt,
  input  logic                      i_count_clear,
  output logic                      o_PCWrite,
  output logic                      o_if_id_write,
  output logic                      o_control_mux,
  output logic                      o_if_id_flush,
  output logic                      o_pipe_enable,
  output logic [1:0]                o_state,
  output logic [COUNT_BITS-1:0]     o_load_stall_count,
  output logic [COUNT_BITS-1:0]     o_mem_stall_count
);

  hazard_state_e             state;
  logic                      mem_wait;
  logic                      freeze;
  logic                      hazard;
  logic                      load_stall;
  logic                      load_enter;
  logic [LOAD_LATENCY-1:0]   ent_valid;
  logic [LOAD_LATENCY-1:0]   ent_match;
  logic [REG_ADDRS_BITS-1:0] ent_rd [LOAD_LATENCY];
  logic                      unused_oldest;

  assign mem_wait = i_mem_req && !i_mem_ready;
  assign freeze   = (state == HALT) || mem_wait;
  assign hazard   = |ent_match;

  always_comb begin
    o_PCWrite     = 1'b1;
    o_if_id_write = 1'b1;
    o_control_mux = 1'b1;
    o_if_id_flush = 1'b0;
    o_pipe_enable = 1'b1;
    load_stall    = 1'b0;
    if (!i_rst) begin
      if (freeze) begin
        o_pipe_enable = 1'b0;
        o_PCWrite     = 1'b0;
        o_if_id_write = 1'b0;
      end else if (i_branch_taken) begin
        // The ID instruction is squashed, so its hazard is irrelevant.
        o_if_id_flush = 1'b1;
        o_control_mux = 1'b0;
      end else if (hazard) begin
        o_PCWrite     = 1'b0;
        o_if_id_write = 1'b0;
        o_control_mux = 1'b0;
        load_stall    = 1'b1;
      end
    end
  end

  // Only a load that actually proceeds into EX becomes a pending producer.
  assign load_enter = i_id_MemRead && o_control_mux && !o_if_id_flush;

  for (genvar g = 0; g < LOAD_LATENCY; g++) begin : g_entry
    logic                      next_valid;
    logic [REG_ADDRS_BITS-1:0] next_rd;
    if (g == 0) begin : g_head
      assign next_valid = load_enter;
      assign next_rd    = load_enter ? i_id_rt : '0;
    end else begin : g_tail
      assign next_valid = ent_valid[g-1];
      assign next_rd    = ent_rd[g-1];
    end
    load_scoreboard_entry #(
      .REG_ADDRS_BITS(REG_ADDRS_BITS)
    ) u_entry (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_shift     (o_pipe_enable),
      .i_next_valid(next_valid),
      .i_next_rd   (next_rd),
      .i_id_rs     (i_id_rs),
      .i_id_rt     (i_id_rt),
      .i_id_uses_rs(i_id_uses_rs),
      .i_id_uses_rt(i_id_uses_rt),
      .o_valid     (ent_valid[g]),
      .o_rd        (ent_rd[g]),
      .o_match     (ent_match[g])
    );
  end

  // The oldest slot falls off the end of the chain on every shift.
  assign unused_oldest = ^{ent_valid[LOAD_LATENCY-1], ent_rd[LOAD_LATENCY-1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= RUN;
      o_load_stall_count <= '0;
      o_mem_stall_count  <= '0;
    end else begin
      // Halt is sticky while requested but never starts over an open memory access.
      if (i_halt && ((state == HALT) || !mem_wait)) state <= HALT;
      else if (mem_wait)                            state <= MEM_WAIT;
      else if (load_stall)                          state <= LOAD_STALL;
      else                                          state <= RUN;

      if (i_count_clear)
        o_load_stall_count <= '0;
      else if (load_stall && !(&o_load_stall_count))
        o_load_stall_count <= o_load_stall_count + COUNT_BITS'(1);

      if (i_count_clear)
        o_mem_stall_count <= '0;
      else if (mem_wait && !(&o_mem_stall_count))
        o_mem_stall_count <= o_mem_stall_count + COUNT_BITS'(1);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench for load_hazard_scoreboard: three instances (latency 1/2/3, one with a
// 4-bit counter) on shared stimulus, each compared against a behavioural model.
module tb_load_hazard_scoreboard;

  localparam int EW = 39;  // {ctl[4:0], state[1:0], load_cnt[15:0], mem_cnt[15:0]}

  // ---------------- clock / reset / shared inputs ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt;
  logic       uses_rs, uses_rt, mem_read, branch, mem_req, mem_ready, halt, count_clear;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [4:0]  ctl_obs   [3];  // {PCWrite, if_id_write, control_mux, if_id_flush, pipe_enable}
  logic [1:0]  state_obs [3];
  logic [15:0] lc_obs    [3];
  logic [15:0] mc_obs    [3];

  for (genvar d = 0; d < 3; d++) begin : g_dut
    localparam int CB = (d == 0) ? 4 : 16;
    logic pcw, ifw, cmux, flush, pen;
    logic [1:0]    st;
    logic [CB-1:0] lc, mc;
    load_hazard_scoreboard #(
      .REG_ADDRS_BITS(5),
      .LOAD_LATENCY  (d + 1),
      .COUNT_BITS    (CB)
    ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_id_rs           (id_rs),
      .i_id_rt           (id_rt),
      .i_id_uses_rs      (uses_rs),
      .i_id_uses_rt      (uses_rt),
      .i_id_MemRead      (mem_read),
      .i_branch_taken    (branch),
      .i_mem_req         (mem_req),
      .i_mem_ready       (mem_ready),
      .i_halt            (halt),
      .i_count_clear     (count_clear),
      .o_PCWrite         (pcw),
      .o_if_id_write     (ifw),
      .o_control_mux     (cmux),
      .o_if_id_flush     (flush),
      .o_pipe_enable     (pen),
      .o_state           (st),
      .o_load_stall_count(lc),
      .o_mem_stall_count (mc)
    );
    assign ctl_obs[d]   = {pcw, ifw, cmux, flush, pen};
    assign state_obs[d] = st;
    assign lc_obs[d]    = 16'(lc);
    assign mc_obs[d]    = 16'(mc);
  end

  // ---------------- reference model ----------------
  int          lat  [3];
  logic [15:0] cmax [3];
  logic        mv   [3][4];
  logic [4:0]  mrd  [3][4];
  logic [1:0]  mst  [3];
  logic [15:0] mlc  [3];
  logic [15:0] mmc  [3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        mv[d][i]  = 1'b0;
        mrd[d][i] = 5'd0;
      end
      mst[d] = 2'd0;
      mlc[d] = 16'd0;
      mmc[d] = 16'd0;
    end
  endtask

  // Returns the expected outputs for this cycle and advances the model one clock.
  task automatic model_step(input int d, output logic [EW-1:0] e);
    logic       haz, memw, frz, stall;
    logic [4:0] ctl;
    logic [1:0] nst;
    int         n;
    n   = lat[d];
    haz = 1'b0;
    for (int i = 0; i < n; i++)
      if (mv[d][i] && mrd[d][i] != 5'd0 &&
          ((uses_rs && mrd[d][i] == id_rs) || (uses_rt && mrd[d][i] == id_rt)))
        haz = 1'b1;
    memw  = mem_req && !mem_ready;
    frz   = (mst[d] == 2'd3) || memw;
    stall = 1'b0;
    if (rst)         ctl = 5'b11101;
    else if (frz)    ctl = 5'b00100;
    else if (branch) ctl = 5'b11011;
    else if (haz) begin
      ctl   = 5'b00001;
      stall = 1'b1;
    end else         ctl = 5'b11101;
    e = {ctl, mst[d], mlc[d], mmc[d]};

    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mv[d][i]  = 1'b0;
        mrd[d][i] = 5'd0;
      end
      mst[d] = 2'd0;
      mlc[d] = 16'd0;
      mmc[d] = 16'd0;
    end else begin
      if (ctl[0]) begin
        for (int i = n - 1; i > 0; i--) begin
          mv[d][i]  = mv[d][i-1];
          mrd[d][i] = mrd[d][i-1];
        end
        mv[d][0]  = mem_read && ctl[2] && !ctl[1];
        mrd[d][0] = mv[d][0] ? id_rt : 5'd0;
      end
      if (halt && mst[d] == 2'd3) nst = 2'd3;
      else if (halt && !memw)     nst = 2'd3;
      else if (memw)              nst = 2'd2;
      else if (stall)             nst = 2'd1;
      else                        nst = 2'd0;
      mst[d] = nst;
      if (count_clear)                   mlc[d] = 16'd0;
      else if (stall && mlc[d] != cmax[d]) mlc[d] = mlc[d] + 16'd1;
      if (count_clear)                   mmc[d] = 16'd0;
      else if (memw && mmc[d] != cmax[d])  mmc[d] = mmc[d] + 16'd1;
    end
  endtask

  // ---------------- scoreboard / checking ----------------
  logic [EW-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pcw_low [3];
  int pen_low [3];
  int flush_seen [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 3; d++) begin
      pcw_low[d]    = 0;
      pen_low[d]    = 0;
      flush_seen[d] = 0;
    end
  endtask

  // Inputs are already applied (posedge+1); compare at negedge, return at next posedge+1.
  task automatic cycle();
    logic [EW-1:0] e;
    for (int d = 0; d < 3; d++) begin
      model_step(d, e);
      exp_q.push_back(e);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      e = exp_q.pop_front();
      check($sformatf("ctl[%0d]@%0d", d, cyc),   32'(ctl_obs[d]),   32'(e[38:34]));
      check($sformatf("state[%0d]@%0d", d, cyc), 32'(state_obs[d]), 32'(e[33:32]));
      check($sformatf("lcnt[%0d]@%0d", d, cyc),  32'(lc_obs[d]),    32'(e[31:16]));
      check($sformatf("mcnt[%0d]@%0d", d, cyc),  32'(mc_obs[d]),    32'(e[15:0]));
      if (!ctl_obs[d][4]) pcw_low[d]++;
      if (!ctl_obs[d][0]) pen_low[d]++;
      if (ctl_obs[d][1])  flush_seen[d]++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; uses_rs = 1'b0; uses_rt = 1'b0; mem_read = 1'b0;
    branch = 1'b0; mem_req = 1'b0; mem_ready = 1'b1; halt = 1'b0;
    count_clear = 1'b0; rst = 1'b0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mr);
    id_rs = rs; id_rt = rt; uses_rs = urs; uses_rt = urt; mem_read = mr;
  endtask

  task automatic clear_counts();
    idle();
    count_clear = 1'b1;
    cycle();
    count_clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    lat[0] = 1; lat[1] = 2; lat[2] = 3;
    cmax[0] = 16'h000f; cmax[1] = 16'hffff; cmax[2] = 16'hffff;
    clear_obs();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();                             // reset state
    idle();

    // Back-to-back load-use: stall length equals the load latency.
    clear_obs();
    instr(5'd1, 5'd3, 1, 0, 1); cycle();
    instr(5'd3, 5'd5, 1, 1, 0); cycle();
    check("s1_state_l1", 32'(state_obs[0]), 32'd1);
    repeat (3) cycle();
    idle(); repeat (3) cycle();
    check("s1_stall_l1", pcw_low[0], 1);
    check("s1_stall_l2", pcw_low[1], 2);
    check("s1_stall_l3", pcw_low[2], 3);
    check("s1_lcnt_l1", 32'(lc_obs[0]), 32'd1);

    // One independent instruction between load and use.
    clear_counts(); clear_obs();
    instr(5'd1, 5'd7, 1, 0, 1); cycle();
    instr(5'd1, 5'd2, 1, 1, 0); cycle();
    instr(5'd7, 5'd4, 1, 1, 0); repeat (4) cycle();
    idle(); repeat (3) cycle();
    check("gap_l1", pcw_low[0], 0);
    check("gap_l2", pcw_low[1], 1);
    check("gap_l3", pcw_low[2], 2);

    // rt named but not read; then a load to r0.
    clear_obs();
    instr(5'd1, 5'd6, 1, 0, 1); cycle();
    instr(5'd1, 5'd6, 1, 0, 0); repeat (4) cycle();
    instr(5'd1, 5'd0, 1, 0, 1); cycle();
    instr(5'd0, 5'd0, 1, 1, 0); repeat (4) cycle();
    idle(); repeat (3) cycle();
    check("no_use_or_r0_l3", pcw_low[2], 0);

    // Memory wait during a pending hazard freezes without aging the scoreboard.
    clear_counts(); clear_obs();
    instr(5'd1, 5'd3, 1, 0, 1); cycle();
    instr(5'd3, 5'd5, 1, 1, 0); cycle();
    mem_req = 1'b1; mem_ready = 1'b0; repeat (4) cycle();
    mem_req = 1'b0; mem_ready = 1'b1; repeat (3) cycle();
    idle(); repeat (3) cycle();
    check("mw_freeze_l2", pen_low[1], 4);
    check("mw_mcnt_l2", 32'(mc_obs[1]), 32'd4);
    check("mw_lcnt_l2", 32'(lc_obs[1]), 32'd2);

    // Taken branch beats a hazard; a squashed load is never recorded.
    clear_counts(); clear_obs();
    instr(5'd1, 5'd3, 1, 0, 1); cycle();
    instr(5'd3, 5'd5, 1, 1, 0); branch = 1'b1; cycle();
    idle(); repeat (3) cycle();
    instr(5'd1, 5'd9, 1, 0, 1); branch = 1'b1; cycle();
    branch = 1'b0;
    instr(5'd9, 5'd5, 1, 1, 0); repeat (4) cycle();
    idle(); repeat (3) cycle();
    check("br_flush_l3", flush_seen[2], 2);
    check("br_nostall_l3", pcw_low[2], 0);
    check("br_lcnt_l3", 32'(lc_obs[2]), 32'd0);

    // Debug halt for three cycles.
    clear_obs();
    check("halt_pre", 32'(state_obs[1]), 32'd0);
    halt = 1'b1; cycle();
    check("halt_enter", 32'(state_obs[1]), 32'd3);
    repeat (2) cycle();
    halt = 1'b0; cycle();
    check("halt_exit", 32'(state_obs[1]), 32'd0);
    check("halt_freeze", pen_low[1], 3);

    // 20 load-use stalls: the 4-bit counter saturates.
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      instr(5'd1, 5'd3, 1, 0, 1); cycle();
      instr(5'd3, 5'd5, 1, 1, 0); cycle();
    end
    idle(); repeat (3) cycle();
    check("sat_l1", 32'(lc_obs[0]), 32'd15);
    check("nosat_l2", 32'(lc_obs[1]), 32'd20);
    clear_counts();
    check("clear_l1", 32'(lc_obs[0]), 32'd0);

    // Reset in the middle of a stall discards the pending load.
    instr(5'd1, 5'd3, 1, 0, 1); cycle();
    instr(5'd3, 5'd5, 1, 1, 0); cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; clear_obs(); cycle();
    check("rst_pcw_l3", pcw_low[2], 0);
    idle(); repeat (2) cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0));
      branch      = ($urandom_range(0, 9) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      count_clear = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
